mips_ctrl_pipe: RTL and testbench
=================================

// Module: mips_ctrl_pipe
// PURPOSE
//  Parametrised MIPS control unit: decodes the ID-stage instruction into a control word and carries it
//  through registered EX/MEM/WB control stages with valid bits. Detects load-use hazards and inserts bubbles.
//  Handles branch flush from EX. Sits between the IF/ID register and the datapath stage registers.
// PARAMETERS
//  CTRL_W      12  control word width, >=12; bits above 11 always 0
//  LOAD_STALL  1   bubbles inserted per load-use hazard, 1..7 (covers data-memory latency)
//  CNT_W       3   stall counter width, must hold LOAD_STALL
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-low
//  in_valid       in   1       in_instruction is a real instruction
//  in_instruction in   32      ID-stage instruction
//  in_flush       in   1       branch/jump taken in EX; kill ID instruction
//  out_stall      out  1       hold PC and IF/ID this cycle
//  out_illegal    out  1       ID opcode not decodable (combinational, qualified by in_valid)
//  out_ex_ctrl    out  CTRL_W  EX-stage control;  out_ex_valid  out 1
//  out_mem_ctrl   out  CTRL_W  MEM-stage control; out_mem_valid out 1
//  out_wb_ctrl    out  CTRL_W  WB-stage control;  out_wb_valid  out 1
//  out_wb_dst     out  5       WB destination register
// BEHAVIOUR
//  Word bits: [0]RegDst [1]ALUSrc [4:2]ALUOp [5]Branch [6]BranchNE [7]MemRead [8]MemWrite [9]RegWrite
//   [10]MemToReg [11]Jump. ALUOp: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 lui.
//  Decode (op): 0 R=0x209; 35 lw, 32 lb=0x682; 43 sw=0x102; 4 beq=0x024; 5 bne=0x064; 8 addi=0x202;
//   12 andi=0x20E; 13 ori=0x212; 10 slti=0x216; 15 lui=0x21A. Other op: word 0, out_illegal=1.
//  No don't-cares: every unused bit is 0. Destination = rd if RegDst, else rt; 0 if RegWrite=0.
//  Reset: all out_*_ctrl/valid/dst = 0, FSM IDLE, counter 0; out_stall 0. Reset mid-stall clears immediately.
//  Pipeline: EX<-ID, MEM<-EX, WB<-MEM every cycle; MEM/WB never stall. Latency ID->EX 1 cycle, ->WB 3 cycles.
//  Hazard (comb.): ex_valid & ex MemRead & ex_dst!=0 & in_valid & (ex_dst==rs | (ex_dst==rt & ID reads rt:
//   R, sw, beq, bne)).
//  FSM IDLE: hazard & !in_flush -> STALL, cnt=LOAD_STALL-1; out_stall=1; EX loads bubble (ctrl 0, valid 0).
//  FSM STALL: out_stall=1, bubble into EX; cnt==0 -> IDLE (ID instruction issues next cycle), else cnt--.
//  in_flush: EX loads bubble, out_stall=0, FSM -> IDLE; flush overrides hazard and STALL.
//  Illegal or !in_valid: EX loads bubble; no stall.
//  ID/EX load only when IDLE, !hazard, !in_flush, in_valid, legal.
// CONFIGURATION
//  CTRL_JUMP_EN defined: op 2 j=0x800; op 3 jal=0xA00, dst forced to 31. Jump never triggers hazard.
//  CTRL_JUMP_EN undefined: ops 2/3 illegal, word 0, out_illegal=1; bit 11 always 0.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode localparams, control-bit indices, ALUOp codes, FSM state enum (IDLE/STALL).
//  Sub-module mips_ctrl_decode: combinational instruction -> {ctrl word, dst, reads_rt, illegal}.
//  Top holds hazard compare, stall FSM/counter, three stage registers.
// TESTING
//  1 Reset low mid-STALL -> all outputs 0 same cycle, FSM IDLE after release.
//  2 0x01095020 (add $10,$8,$9) -> next cycle out_ex_ctrl=0x209, ex_valid=1; 2 cycles later wb_dst=10.
//  3 0x8C080000 (lw $8) then 0x01084820 (add $9,$8,$8), LOAD_STALL=1 -> out_stall=1 for 1 cycle,
//    one bubble in EX, add in EX on cycle 3; LOAD_STALL=3 -> 3 stall cycles, 3 bubbles.
//  4 lw $8 then 0x21090004 (addi $9,$8,4) with in_flush=1 in hazard cycle -> no stall, EX bubble.
//  5 Op 0x3F -> out_illegal=1, EX bubble; op 3 -> illegal without CTRL_JUMP_EN, 0xA00/dst 31 with it.
//  6 lw $0 then add $9,$0,$0 -> no stall; sw rt=$8 after lw $8 -> stall.

Source files
------------

// File: rtl/mips_ctrl_pipe_pkg.sv
// Shared definitions for the MIPS control pipeline: opcodes, control-word
// bit positions, ALUOp encodings and the stall FSM state type.
package mips_ctrl_pkg;

  localparam int BASE_W = 12;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam int B_REGDST   = 0;
  localparam int B_ALUSRC   = 1;
  localparam int B_ALUOP    = 2;   // 3-bit field [4:2]
  localparam int B_BRANCH   = 5;
  localparam int B_BRANCHNE = 6;
  localparam int B_MEMREAD  = 7;
  localparam int B_MEMWRITE = 8;
  localparam int B_REGWRITE = 9;
  localparam int B_MEMTOREG = 10;
  localparam int B_JUMP     = 11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/mips_ctrl_pipe_if.sv
// Bus between the IF/ID side (master: supplies instructions, flush) and the
// control pipeline (slave: returns stall, illegal and staged control words).
interface mips_ctrl_pipe_if #(
  parameter int CTRL_W = 12
);
  logic              in_valid;
  logic [31:0]       in_instruction;
  logic              in_flush;
  logic              out_stall;
  logic              out_illegal;
  logic [CTRL_W-1:0] out_ex_ctrl;
  logic              out_ex_valid;
  logic [CTRL_W-1:0] out_mem_ctrl;
  logic              out_mem_valid;
  logic [CTRL_W-1:0] out_wb_ctrl;
  logic              out_wb_valid;
  logic [4:0]        out_wb_dst;

  modport master (
    output in_valid, in_instruction, in_flush,
    input  out_stall, out_illegal, out_ex_ctrl, out_ex_valid,
           out_mem_ctrl, out_mem_valid, out_wb_ctrl, out_wb_valid, out_wb_dst
  );

  modport slave (
    input  in_valid, in_instruction, in_flush,
    output out_stall, out_illegal, out_ex_ctrl, out_ex_valid,
           out_mem_ctrl, out_mem_valid, out_wb_ctrl, out_wb_valid, out_wb_dst
  );
endinterface

// File: rtl/mips_ctrl_pipe_decode.sv
// Combinational opcode decode: control word, destination register, and which
// source fields the instruction actually reads (used by the hazard compare).
// Optional macro CTRL_JUMP_EN adds j/jal decode; without it ops 2/3 are illegal.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int CTRL_W = 12
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic [4:0]        dst,
  output logic              reads_rs,
  output logic              reads_rt,
  output logic              illegal
);

  logic [5:0]        op;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [BASE_W-1:0] w;
  logic              is_jal;
  logic              unused_bits;

  assign op          = instr[31:26];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign unused_bits = ^instr[10:0];

  // opcode -> control bits; anything not listed decodes to an all-zero word
  always_comb begin
    w        = '0;
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    illegal  = 1'b0;
    is_jal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        w[B_REGDST]        = 1'b1;
        w[B_ALUOP +: 3]    = ALU_FUNCT;
        w[B_REGWRITE]      = 1'b1;
        reads_rt           = 1'b1;
      end
      OP_LW, OP_LB: begin
        w[B_ALUSRC]        = 1'b1;
        w[B_ALUOP +: 3]    = ALU_ADD;
        w[B_MEMREAD]       = 1'b1;
        w[B_REGWRITE]      = 1'b1;
        w[B_MEMTOREG]      = 1'b1;
      end
      OP_SW: begin
        w[B_ALUSRC]        = 1'b1;
        w[B_MEMWRITE]      = 1'b1;
        reads_rt           = 1'b1;
      end
      OP_BEQ: begin
        w[B_ALUOP +: 3]    = ALU_SUB;
        w[B_BRANCH]        = 1'b1;
        reads_rt           = 1'b1;
      end
      OP_BNE: begin
        w[B_ALUOP +: 3]    = ALU_SUB;
        w[B_BRANCH]        = 1'b1;
        w[B_BRANCHNE]      = 1'b1;
        reads_rt           = 1'b1;
      end
      OP_ADDI: begin
        w[B_ALUSRC]        = 1'b1;
        w[B_REGWRITE]      = 1'b1;
      end
      OP_ANDI: begin
        w[B_ALUSRC]        = 1'b1;
        w[B_ALUOP +: 3]    = ALU_AND;
        w[B_REGWRITE]      = 1'b1;
      end
      OP_ORI: begin
        w[B_ALUSRC]        = 1'b1;
        w[B_ALUOP +: 3]    = ALU_OR;
        w[B_REGWRITE]      = 1'b1;
      end
      OP_SLTI: begin
        w[B_ALUSRC]        = 1'b1;
        w[B_ALUOP +: 3]    = ALU_SLT;
        w[B_REGWRITE]      = 1'b1;
      end
      OP_LUI: begin
        w[B_ALUSRC]        = 1'b1;
        w[B_ALUOP +: 3]    = ALU_LUI;
        w[B_REGWRITE]      = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      // jump targets occupy the rs/rt fields, so jumps read no registers
      OP_J: begin
        w[B_JUMP]          = 1'b1;
        reads_rs           = 1'b0;
      end
      OP_JAL: begin
        w[B_JUMP]          = 1'b1;
        w[B_REGWRITE]      = 1'b1;
        reads_rs           = 1'b0;
        is_jal             = 1'b1;
      end
`endif
      default: begin
        illegal            = 1'b1;
        reads_rs           = 1'b0;
      end
    endcase
  end

  // destination: link register for jal, rd/rt by RegDst, 0 when nothing is written
  always_comb begin
    dst = 5'd0;
    if (w[B_REGWRITE]) begin
      if (is_jal)             dst = 5'd31;
      else if (w[B_REGDST])   dst = rd;
      else                    dst = rt;
    end
  end

  assign ctrl = CTRL_W'(w);

endmodule

// File: rtl/mips_ctrl_pipe.sv
// MIPS control pipeline: decodes the ID instruction, carries the control word
// through EX/MEM/WB with valid bits, stalls on load-use, bubbles on flush.
// Optional macro CTRL_JUMP_EN enables j/jal decode.
//
// state | meaning
// IDLE  | normal issue; a load-use hazard here is the first stall cycle
// STALL | extra bubble cycles while a load completes; cnt counts them down
module mips_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 12,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 3
) (
  input logic              clk,
  input logic              rst,
  mips_ctrl_pipe_if.slave  bus
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [4:0]        dec_dst;
  logic              dec_reads_rs;
  logic              dec_reads_rt;
  logic              dec_illegal;

  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic              ex_valid, mem_valid, wb_valid;
  logic [4:0]        ex_dst, mem_dst, wb_dst;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              hazard;
  logic              stall;
  logic              issue;
  logic [4:0]        id_rs, id_rt;

  mips_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
    .instr    (bus.in_instruction),
    .ctrl     (dec_ctrl),
    .dst      (dec_dst),
    .reads_rs (dec_reads_rs),
    .reads_rt (dec_reads_rt),
    .illegal  (dec_illegal)
  );

  assign id_rs = bus.in_instruction[25:21];
  assign id_rt = bus.in_instruction[20:16];

  // load in EX whose result the ID instruction needs
  always_comb begin
    hazard = ex_valid && ex_ctrl[B_MEMREAD] && (ex_dst != 5'd0) &&
             bus.in_valid && !dec_illegal &&
             ((dec_reads_rs && (ex_dst == id_rs)) ||
              (dec_reads_rt && (ex_dst == id_rt)));
  end

  // stall FSM state and bubble counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state: the IDLE hazard cycle is bubble #1, STALL supplies the remaining LOAD_STALL-1
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    if (bus.in_flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard) begin
            stall = 1'b1;
            if (LOAD_STALL > 1) begin
              state_n = STALL;
              cnt_n   = CNT_W'(LOAD_STALL - 1);
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign issue = (state == IDLE) && !hazard && !bus.in_flush &&
                 bus.in_valid && !dec_illegal;

  // EX takes the decoded word or a bubble; MEM and WB always advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_ctrl   <= '0;
      ex_valid  <= 1'b0;
      ex_dst    <= 5'd0;
      mem_ctrl  <= '0;
      mem_valid <= 1'b0;
      mem_dst   <= 5'd0;
      wb_ctrl   <= '0;
      wb_valid  <= 1'b0;
      wb_dst    <= 5'd0;
    end else begin
      ex_ctrl   <= issue ? dec_ctrl : '0;
      ex_valid  <= issue;
      ex_dst    <= issue ? dec_dst : 5'd0;
      mem_ctrl  <= ex_ctrl;
      mem_valid <= ex_valid;
      mem_dst   <= ex_dst;
      wb_ctrl   <= mem_ctrl;
      wb_valid  <= mem_valid;
      wb_dst    <= mem_dst;
    end
  end

  assign bus.out_stall     = stall;
  assign bus.out_illegal   = bus.in_valid && dec_illegal;
  assign bus.out_ex_ctrl   = ex_ctrl;
  assign bus.out_ex_valid  = ex_valid;
  assign bus.out_mem_ctrl  = mem_ctrl;
  assign bus.out_mem_valid = mem_valid;
  assign bus.out_wb_ctrl   = wb_ctrl;
  assign bus.out_wb_valid  = wb_valid;
  assign bus.out_wb_dst    = wb_dst;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Testbench for mips_ctrl_pipe: scoreboard on a LOAD_STALL=1 instance plus
// directed checks of multi-cycle stall, flush and reset on a LOAD_STALL=3 instance.
module tb_mips_ctrl_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_ctrl_pipe_if #(.CTRL_W(12)) bus1 ();
  mips_ctrl_pipe_if #(.CTRL_W(12)) bus3 ();

  mips_ctrl_pipe #(.CTRL_W(12), .LOAD_STALL(1), .CNT_W(3)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  mips_ctrl_pipe #(.CTRL_W(12), .LOAD_STALL(3), .CNT_W(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  typedef struct {
    int         due;
    logic       v;
    logic [11:0] ctrl;
    logic [4:0]  dst;
  } exp_t;

  exp_t exq[$];
  exp_t wbq[$];
  exp_t me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare EX and WB stages against the scoreboard on the entry's due cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        while (exq.size() > 0 && exq[0].due < cyc) begin
          me = exq.pop_front();
          n_chk++; n_fail++;
          $display("FAIL ex_missed: entry due %0d not checked (cycle %0d)", me.due, cyc);
        end
        if (exq.size() > 0 && exq[0].due == cyc) begin
          me = exq.pop_front();
          chk("ex_valid", bus1.out_ex_valid, me.v);
          chk("ex_ctrl",  bus1.out_ex_ctrl,  me.ctrl);
        end
        if (wbq.size() > 0 && wbq[0].due == cyc) begin
          me = wbq.pop_front();
          chk("wb_valid", bus1.out_wb_valid, me.v);
          chk("wb_ctrl",  bus1.out_wb_ctrl,  me.ctrl);
          chk("wb_dst",   bus1.out_wb_dst,   me.dst);
        end
      end
    end
  end

  // one ID cycle on dut1: check comb outputs, predict issue, push expectations
  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic exp_stall, input logic exp_ill,
                      input logic [11:0] ctrl, input logic [4:0] dst, input string name);
    exp_t e;
    logic iss;
    bus1.in_valid       = v;
    bus1.in_instruction = ins;
    bus1.in_flush       = fl;
    @(negedge clk);
    chk({name, "/stall"},   bus1.out_stall,   exp_stall);
    chk({name, "/illegal"}, bus1.out_illegal, exp_ill);
    iss    = v & !exp_ill & !exp_stall & !fl;
    e.v    = iss;
    e.ctrl = iss ? ctrl : 12'h000;
    e.dst  = iss ? dst  : 5'd0;
    e.due  = cyc + 1;
    exq.push_back(e);
    e.due  = cyc + 3;
    wbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drive3(input logic v, input logic [31:0] ins, input logic fl);
    bus3.in_valid       = v;
    bus3.in_instruction = ins;
    bus3.in_flush       = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.in_valid = 1'b0; bus1.in_instruction = '0; bus1.in_flush = 1'b0;
    drive3(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",     bus1.out_stall,     0);
    chk("rst_ex_ctrl",   bus1.out_ex_ctrl,   0);
    chk("rst_ex_valid",  bus1.out_ex_valid,  0);
    chk("rst_mem_ctrl",  bus1.out_mem_ctrl,  0);
    chk("rst_mem_valid", bus1.out_mem_valid, 0);
    chk("rst_wb_ctrl",   bus1.out_wb_ctrl,   0);
    chk("rst_wb_valid",  bus1.out_wb_valid,  0);
    chk("rst_wb_dst",    bus1.out_wb_dst,    0);
    rst = 1'b1;
    @(posedge clk); #1;

    // basic R-type issue
    step(1, 32'h01095020, 0, 0, 0, 12'h209, 5'd10, "add");
    // load-use on rs/rt: one stall, then issue
    step(1, 32'h8C080000, 0, 0, 0, 12'h682, 5'd8,  "lw8_a");
    step(1, 32'h01084820, 0, 1, 0, 12'h209, 5'd9,  "add_haz");
    step(1, 32'h01084820, 0, 0, 0, 12'h209, 5'd9,  "add_go");
    // flush in the hazard cycle wins: no stall, bubble
    step(1, 32'h8C080000, 0, 0, 0, 12'h682, 5'd8,  "lw8_b");
    step(1, 32'h21090004, 1, 0, 0, 12'h202, 5'd9,  "addi_flush");
    step(1, 32'h21090004, 0, 0, 0, 12'h202, 5'd9,  "addi_go");
    // illegal opcodes, jumps
    step(1, 32'hFC000000, 0, 0, 1, 12'h000, 5'd0,  "op3f");
    step(1, 32'h8C080000, 0, 0, 0, 12'h682, 5'd8,  "lw8_c");
`ifdef CTRL_JUMP_EN
    step(1, 32'h0D000000, 0, 0, 0, 12'hA00, 5'd31, "jal");
    step(1, 32'h08000000, 0, 0, 0, 12'h800, 5'd0,  "j");
`else
    step(1, 32'h0D000000, 0, 0, 1, 12'h000, 5'd0,  "jal_off");
    step(1, 32'h08000000, 0, 0, 1, 12'h000, 5'd0,  "j_off");
`endif
    step(0, 32'hFC000000, 0, 0, 0, 12'h000, 5'd0,  "op3f_invalid");
    // $0 destination never hazards
    step(1, 32'h8C000000, 0, 0, 0, 12'h682, 5'd0,  "lw0");
    step(1, 32'h00004820, 0, 0, 0, 12'h209, 5'd9,  "add_r0");
    // store reads rt
    step(1, 32'h8C080000, 0, 0, 0, 12'h682, 5'd8,  "lw8_d");
    step(1, 32'hAC080000, 0, 1, 0, 12'h102, 5'd0,  "sw_haz");
    step(1, 32'hAC080000, 0, 0, 0, 12'h102, 5'd0,  "sw_go");
    // ori's rt is a destination, not a source
    step(1, 32'h8C080000, 0, 0, 0, 12'h682, 5'd8,  "lw8_e");
    step(1, 32'h35480001, 0, 0, 0, 12'h212, 5'd8,  "ori_rt");
    // invalid ID slot never stalls
    step(1, 32'h8C080000, 0, 0, 0, 12'h682, 5'd8,  "lw8_f");
    step(0, 32'h01084820, 0, 0, 0, 12'h209, 5'd9,  "add_invalid");
    // branch reads rt
    step(1, 32'h8C080000, 0, 0, 0, 12'h682, 5'd8,  "lw8_g");
    step(1, 32'h11280002, 0, 1, 0, 12'h024, 5'd0,  "beq_haz");
    step(1, 32'h11280002, 0, 0, 0, 12'h024, 5'd0,  "beq_go");
    // remaining decodes
    step(1, 32'h3C0A1234, 0, 0, 0, 12'h21A, 5'd10, "lui");
    step(1, 32'h290A0005, 0, 0, 0, 12'h216, 5'd10, "slti");
    step(1, 32'h310A00FF, 0, 0, 0, 12'h20E, 5'd10, "andi");
    step(1, 32'h810A0000, 0, 0, 0, 12'h682, 5'd10, "lb");
    step(1, 32'h15090001, 0, 0, 0, 12'h064, 5'd0,  "bne");
    for (int i = 0; i < 3; i++)
      step(0, 32'h0, 0, 0, 0, 12'h000, 5'd0, "idle");
    repeat (4) @(posedge clk);
    #1;
    chk("exq_drained", exq.size(), 0);
    chk("wbq_drained", wbq.size(), 0);

    // LOAD_STALL=3: three stall cycles, three bubbles, then issue
    drive3(1, 32'h8C080000, 0);
    @(negedge clk);
    chk("ls3_lw_stall", bus3.out_stall, 0);
    @(posedge clk); #1;
    drive3(1, 32'h01084820, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ls3_stall", bus3.out_stall, (i < 3) ? 1 : 0);
      if (i > 0) chk("ls3_bubble", bus3.out_ex_valid, 0);
      @(posedge clk); #1;
    end
    drive3(1, 32'h8C080000, 0);
    @(negedge clk);
    chk("ls3_add_valid", bus3.out_ex_valid, 1);
    chk("ls3_add_ctrl",  bus3.out_ex_ctrl,  12'h209);
    chk("ls3_lw2_stall", bus3.out_stall,    0);
    @(posedge clk); #1;

    // flush overrides an in-progress STALL
    drive3(1, 32'h01084820, 0);
    @(negedge clk);
    chk("ls3_haz2", bus3.out_stall, 1);
    @(posedge clk); #1;
    drive3(1, 32'h01084820, 1);
    @(negedge clk);
    chk("ls3_flush_stall", bus3.out_stall, 0);
    @(posedge clk); #1;
    drive3(1, 32'h01084820, 0);
    @(negedge clk);
    chk("ls3_after_flush_stall", bus3.out_stall,    0);
    chk("ls3_after_flush_ex",    bus3.out_ex_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ls3_after_flush_issue", bus3.out_ex_valid, 1);
    @(posedge clk); #1;

    // reset asserted mid-STALL clears everything at once
    drive3(1, 32'h8C080000, 0);
    @(posedge clk); #1;
    drive3(1, 32'h01084820, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ls3_pre_rst_stall", bus3.out_stall,     1);
    chk("ls3_pre_rst_mem",   bus3.out_mem_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_stall",     bus3.out_stall,     0);
    chk("mrst_ex_ctrl",   bus3.out_ex_ctrl,   0);
    chk("mrst_ex_valid",  bus3.out_ex_valid,  0);
    chk("mrst_mem_ctrl",  bus3.out_mem_ctrl,  0);
    chk("mrst_mem_valid", bus3.out_mem_valid, 0);
    chk("mrst_wb_ctrl",   bus3.out_wb_ctrl,   0);
    chk("mrst_wb_valid",  bus3.out_wb_valid,  0);
    chk("mrst_wb_dst",    bus3.out_wb_dst,    0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", bus3.out_stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_issue_v", bus3.out_ex_valid, 1);
    chk("post_rst_issue_c", bus3.out_ex_ctrl,  12'h209);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
